icache_fill_ctrl: RTL and testbench

//  Miss/refill engine for the 512 B direct-mapped icache. Latches the line address on ic_miss,

---
 rtl/icache_fill_ctrl_pkg.sv | 15 +
 rtl/icache_fill_ctrl_if.sv | 23 ++
 rtl/icache_fill_ctrl_linebuf.sv | 36 +++
 rtl/icache_fill_ctrl.sv | 86 ++++++++
 tb/tb_icache_fill_ctrl.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/icache_fill_ctrl_pkg.sv
// rtl/icache_fill_ctrl_pkg.sv - shared icache line/beat geometry and fill-state encodings
package icache_fill_ctrl_pkg;

  localparam int IC_LINE_BYTES = 32;
  localparam int IC_BEAT_W     = 64;
  localparam int IC_ADDR_W     = 32;
  localparam int IC_NBEATS     = IC_LINE_BYTES * 8 / IC_BEAT_W;
  localparam int IC_OFS_BITS   = $clog2(IC_LINE_BYTES);

  localparam logic [1:0] FILL_IDLE = 2'd0;
  localparam logic [1:0] FILL_REQ  = 2'd1;
  localparam logic [1:0] FILL_BEAT = 2'd2;
  localparam logic [1:0] FILL_ACK  = 2'd3;

endpackage

// File: rtl/icache_fill_ctrl_if.sv
// rtl/icache_fill_ctrl_if.sv - memory bus read port between the fill engine and the arbiter
interface icache_fill_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int BEAT_W = 64
);

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [BEAT_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_addr,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_gnt, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/icache_fill_ctrl_linebuf.sv
// rtl/icache_fill_ctrl_linebuf.sv - NBEATS x BEAT_W line buffer with one-hot beat write
module ic_fill_linebuf
  import icache_fill_ctrl_pkg::*;
#(
  parameter int NBEATS = IC_NBEATS,
  parameter int BEAT_W = IC_BEAT_W,
  parameter int CNT_W  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [CNT_W-1:0]         wr_idx,
  input  logic [BEAT_W-1:0]        wr_data,
  output logic [NBEATS*BEAT_W-1:0] line
);

  logic [NBEATS-1:0] slot_we;

  always_comb begin
    slot_we = '0;
    for (int k = 0; k < NBEATS; k++) begin
      slot_we[k] = wr_en && (wr_idx == CNT_W'(k));
    end
  end

  for (genvar g = 0; g < NBEATS; g++) begin : g_slot
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        line[g*BEAT_W +: BEAT_W] <= '0;
      end else if (slot_we[g]) begin
        line[g*BEAT_W +: BEAT_W] <= wr_data;
      end
    end
  end

endmodule

// File: rtl/icache_fill_ctrl.sv
// rtl/icache_fill_ctrl.sv - icache miss/refill engine: request, collect beats, ack the line
module icache_fill_ctrl
  import icache_fill_ctrl_pkg::*;
#(
  parameter int LINE_BYTES = IC_LINE_BYTES,
  parameter int BEAT_W     = IC_BEAT_W,
  parameter int ADDR_W     = IC_ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ic_miss,
  input  logic [ADDR_W-1:0]       ic_miss_addr,
  input  logic                    ic_exp,
  output logic [8*LINE_BYTES-1:0] ic_fill_data,
  output logic                    ic_miss_ack,
  output logic [ADDR_W-1:0]       ic_miss_ack_addr,
  output logic                    fill_busy,
  icache_fill_ctrl_if.master      mem
);

  localparam int NBEATS = LINE_BYTES * 8 / BEAT_W;
  localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [ADDR_W-1:0] OFS_MASK = ADDR_W'(LINE_BYTES - 1);

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] line_addr;
  logic              beat_we;

  assign beat_we = (state == FILL_BEAT) && mem.mem_rvalid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL_IDLE;
      cnt       <= '0;
      line_addr <= '0;
    end else begin
      case (state)
        FILL_IDLE: begin
          if (ic_miss && !ic_exp) begin
            line_addr <= ic_miss_addr & ~OFS_MASK;
            state     <= FILL_REQ;
          end
        end
        // A grant in the same cycle as a redirect still commits the fill.
        FILL_REQ: begin
          if (mem.mem_gnt) begin
            cnt   <= '0;
            state <= FILL_BEAT;
          end else if (ic_exp) begin
            state <= FILL_IDLE;
          end
        end
        FILL_BEAT: begin
          if (mem.mem_rvalid) begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(NBEATS - 1)) begin
              state <= FILL_ACK;
            end
          end
        end
        default: state <= FILL_IDLE;
      endcase
    end
  end

  ic_fill_linebuf #(
    .NBEATS (NBEATS),
    .BEAT_W (BEAT_W),
    .CNT_W  (CNT_W)
  ) u_linebuf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (beat_we),
    .wr_idx  (cnt),
    .wr_data (mem.mem_rdata),
    .line    (ic_fill_data)
  );

  assign mem.mem_req      = (state == FILL_REQ);
  assign mem.mem_addr     = line_addr;
  assign ic_miss_ack      = (state == FILL_ACK);
  assign ic_miss_ack_addr = line_addr;
  assign fill_busy        = (state != FILL_IDLE);

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// tb/tb_icache_fill_ctrl.sv - self-checking bench for icache_fill_ctrl
module tb_icache_fill_ctrl;

  localparam int AW = 32;
  localparam int BW = 64;
  localparam int NB = 4;
  localparam int LW = 256;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ic_miss = 1'b0;
  logic [AW-1:0] ic_miss_addr = '0;
  logic          ic_exp = 1'b0;
  logic [LW-1:0] ic_fill_data;
  logic          ic_miss_ack;
  logic [AW-1:0] ic_miss_ack_addr;
  logic          fill_busy;

  always #5 clk = ~clk;

  icache_fill_ctrl_if #(.ADDR_W(AW), .BEAT_W(BW)) bus ();

  icache_fill_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ic_miss          (ic_miss),
    .ic_miss_addr     (ic_miss_addr),
    .ic_exp           (ic_exp),
    .ic_fill_data     (ic_fill_data),
    .ic_miss_ack      (ic_miss_ack),
    .ic_miss_ack_addr (ic_miss_ack_addr),
    .fill_busy        (fill_busy),
    .mem              (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [BW-1:0] stim_beats[NB];
  int            stim_gaps[NB];
  int            stim_gnt_dly;
  bit            stim_exp;
  bit            stim_noise;

  int            obs_ack_cnt;
  int            obs_ack_cyc;
  int            obs_bad;
  logic [LW-1:0] obs_data;
  logic [AW-1:0] obs_addr;

  function automatic logic [LW-1:0] model_line();
    logic [LW-1:0] l;
    for (int k = 0; k < NB; k++) l[k*BW +: BW] = stim_beats[k];
    return l;
  endfunction

  function automatic int model_latency();
    int s;
    s = 6 + stim_gnt_dly;
    for (int k = 0; k < NB; k++) s += stim_gaps[k];
    return s;
  endfunction

  function automatic logic [AW-1:0] model_align(input logic [AW-1:0] a);
    return a & ~32'd31;
  endfunction

  task automatic randomize_stim();
    for (int k = 0; k < NB; k++) begin
      stim_beats[k] = {$urandom, $urandom};
      stim_gaps[k]  = $urandom_range(0, 3);
    end
    stim_gnt_dly = $urandom_range(0, 4);
  endtask

  // Drives one miss through grant and beats, recording what the icache side saw.
  task automatic drive_fill(input logic [AW-1:0] addr);
    int cyc;
    logic [AW-1:0] la;
    la = model_align(addr);
    obs_ack_cnt = 0;
    obs_ack_cyc = -1;
    obs_bad     = 0;
    obs_data    = '0;
    obs_addr    = '0;
    @(negedge clk);
    ic_miss = 1'b1; ic_miss_addr = addr; ic_exp = 1'b0; cyc = 0;
    @(negedge clk);
    ic_miss = 1'b0; cyc = 1;
    for (int d = 0; d <= stim_gnt_dly; d++) begin
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== la || fill_busy !== 1'b1 || ic_miss_ack !== 1'b0)
        obs_bad++;
      bus.mem_gnt = (d == stim_gnt_dly);
      ic_exp      = stim_exp && (d == stim_gnt_dly);
      @(negedge clk); cyc++;
    end
    bus.mem_gnt = 1'b0;
    for (int k = 0; k < NB; k++) begin
      for (int g = 0; g < stim_gaps[k]; g++) begin
        if (bus.mem_req !== 1'b0 || ic_miss_ack !== 1'b0 || fill_busy !== 1'b1) obs_bad++;
        bus.mem_rvalid = 1'b0;
        ic_exp = stim_exp;
        if (stim_noise) begin ic_miss = 1'($urandom_range(0, 1)); ic_miss_addr = 32'h0000_7FE0; end
        @(negedge clk); cyc++;
      end
      if (bus.mem_req !== 1'b0 || ic_miss_ack !== 1'b0 || fill_busy !== 1'b1) obs_bad++;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = stim_beats[k];
      ic_exp = stim_exp;
      if (stim_noise) begin ic_miss = 1'b1; ic_miss_addr = 32'h0000_7FE0; end
      @(negedge clk); cyc++;
    end
    bus.mem_rvalid = 1'b0;
    ic_miss = 1'b0; ic_exp = 1'b0; ic_miss_addr = addr;
    for (int w = 0; w < 8; w++) begin
      if (ic_miss_ack === 1'b1) begin
        obs_ack_cnt++;
        if (obs_ack_cyc < 0) begin
          obs_ack_cyc = cyc; obs_data = ic_fill_data; obs_addr = ic_miss_ack_addr;
        end
      end
      @(negedge clk); cyc++;
    end
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if ({ic_fill_data, ic_miss_addr} !== {{LW{1'b0}}, ic_miss_addr} || ic_fill_data !== '0) begin
      n_fail++; $display("FAIL reset_fill_data: got %h expected 0", ic_fill_data);
    end
    n_checks++;
    if ({bus.mem_req, ic_miss_ack, fill_busy} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl: got req/ack/busy=%b expected 000", {bus.mem_req, ic_miss_ack, fill_busy});
    end
    n_checks++;
    if (bus.mem_addr !== '0 || ic_miss_ack_addr !== '0) begin
      n_fail++; $display("FAIL reset_addrs: got mem_addr=%h ack_addr=%h expected 0", bus.mem_addr, ic_miss_ack_addr);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic check_fill(input string name, input logic [AW-1:0] addr);
    n_checks++;
    if (obs_ack_cnt !== 1) begin n_fail++; $display("FAIL %s_ack_count: got %0d expected 1", name, obs_ack_cnt); end
    n_checks++;
    if (obs_ack_cyc !== model_latency()) begin n_fail++; $display("FAIL %s_latency: got %0d expected %0d", name, obs_ack_cyc, model_latency()); end
    n_checks++;
    if (obs_addr !== model_align(addr)) begin n_fail++; $display("FAIL %s_ack_addr: got %h expected %h", name, obs_addr, model_align(addr)); end
    n_checks++;
    if (obs_data !== model_line()) begin n_fail++; $display("FAIL %s_data: got %h expected %h", name, obs_data, model_line()); end
    n_checks++;
    if (obs_bad !== 0) begin n_fail++; $display("FAIL %s_bus_protocol: got %0d bad cycles expected 0", name, obs_bad); end
  endtask

  task automatic test_basic();
    stim_beats[0] = 64'h1111_1111_1111_1111;
    stim_beats[1] = 64'h2222_2222_2222_2222;
    stim_beats[2] = 64'h3333_3333_3333_3333;
    stim_beats[3] = 64'h4444_4444_4444_4444;
    for (int k = 0; k < NB; k++) stim_gaps[k] = 0;
    stim_gnt_dly = 0; stim_exp = 1'b0; stim_noise = 1'b0;
    drive_fill(32'h0000_1A40);
    check_fill("basic", 32'h0000_1A40);
  endtask

  task automatic test_delayed_gnt();
    stim_gnt_dly = 5;
    stim_gaps[0] = 0; stim_gaps[1] = 0; stim_gaps[2] = 3; stim_gaps[3] = 1;
    drive_fill(32'h0000_1A5C);
    check_fill("delayed_gnt", 32'h0000_1A5C);
  endtask

  task automatic test_exp();
    int acks;
    @(negedge clk); ic_miss = 1'b1; ic_miss_addr = 32'h0000_0300;
    @(negedge clk); ic_miss = 1'b0;
    n_checks++;
    if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL exp_req_before: got %b expected 1", bus.mem_req); end
    ic_exp = 1'b1; bus.mem_gnt = 1'b0;
    @(negedge clk); ic_exp = 1'b0;
    n_checks++;
    if ({bus.mem_req, fill_busy} !== 2'b00) begin n_fail++; $display("FAIL exp_cancel: got req/busy=%b expected 00", {bus.mem_req, fill_busy}); end
    acks = 0;
    for (int w = 0; w < 6; w++) begin if (ic_miss_ack === 1'b1) acks++; @(negedge clk); end
    n_checks++;
    if (acks !== 0) begin n_fail++; $display("FAIL exp_no_ack: got %0d acks expected 0", acks); end
    ic_miss = 1'b1; ic_exp = 1'b1;
    @(negedge clk); ic_miss = 1'b0; ic_exp = 1'b0;
    n_checks++;
    if (fill_busy !== 1'b0) begin n_fail++; $display("FAIL exp_same_cycle_miss: got busy=%b expected 0", fill_busy); end
    randomize_stim(); stim_exp = 1'b1;
    drive_fill(32'h0000_0440);
    stim_exp = 1'b0;
    check_fill("exp_with_gnt", 32'h0000_0440);
  endtask

  task automatic test_miss_during_beat();
    randomize_stim(); stim_noise = 1'b1;
    drive_fill(32'h0000_1A40);
    stim_noise = 1'b0;
    check_fill("miss_in_beat", 32'h0000_1A40);
    n_checks++;
    if (fill_busy !== 1'b0) begin n_fail++; $display("FAIL miss_in_beat_idle: got busy=%b expected 0", fill_busy); end
    randomize_stim();
    drive_fill(32'h0000_7FE0);
    check_fill("miss_after_idle", 32'h0000_7FE0);
  endtask

  task automatic test_reset_mid_fill();
    @(negedge clk); ic_miss = 1'b1; ic_miss_addr = 32'h0000_2B80;
    @(negedge clk); ic_miss = 1'b0; bus.mem_gnt = 1'b1;
    @(negedge clk); bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'hAAAA_0000_0000_0001;
    @(negedge clk); bus.mem_rdata = 64'hAAAA_0000_0000_0002;
    @(negedge clk); bus.mem_rvalid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (ic_fill_data !== '0) begin n_fail++; $display("FAIL rst_mid_data: got %h expected 0", ic_fill_data); end
    n_checks++;
    if ({bus.mem_req, ic_miss_ack, fill_busy} !== 3'b000 || bus.mem_addr !== '0 || ic_miss_ack_addr !== '0) begin
      n_fail++; $display("FAIL rst_mid_ctrl: got busy=%b mem_addr=%h ack_addr=%h expected 0", fill_busy, bus.mem_addr, ic_miss_ack_addr);
    end
    @(negedge clk); rst_n = 1'b1;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'hAAAA_0000_0000_0003;
    @(negedge clk); bus.mem_rdata = 64'hAAAA_0000_0000_0004;
    @(negedge clk); bus.mem_rvalid = 1'b0;
    n_checks++;
    if (ic_fill_data !== '0 || fill_busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_late_beats: got busy=%b data=%h expected 0", fill_busy, ic_fill_data);
    end
    randomize_stim();
    drive_fill(32'h0000_2B80);
    check_fill("after_reset", 32'h0000_2B80);
  endtask

  task automatic test_rvalid_outside();
    logic [LW-1:0] held;
    held = model_line();
    @(negedge clk); bus.mem_rvalid = 1'b1; bus.mem_rdata = {$urandom, $urandom};
    @(negedge clk); bus.mem_rvalid = 1'b0;
    n_checks++;
    if (ic_fill_data !== held || fill_busy !== 1'b0) begin
      n_fail++; $display("FAIL rvalid_idle: got busy=%b data=%h expected %h", fill_busy, ic_fill_data, held);
    end
    ic_miss = 1'b1; ic_miss_addr = 32'h0000_0600;
    @(negedge clk); ic_miss = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = {$urandom, $urandom};
    @(negedge clk); bus.mem_rvalid = 1'b0;
    n_checks++;
    if (ic_fill_data !== held || bus.mem_req !== 1'b1) begin
      n_fail++; $display("FAIL rvalid_req: got req=%b data=%h expected req=1 data=%h", bus.mem_req, ic_fill_data, held);
    end
    ic_exp = 1'b1;
    @(negedge clk); ic_exp = 1'b0;
    n_checks++;
    if (fill_busy !== 1'b0 || ic_fill_data !== held) begin
      n_fail++; $display("FAIL rvalid_req_cancel: got busy=%b data=%h expected %h", fill_busy, ic_fill_data, held);
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] a;
    for (int i = 0; i < 12; i++) begin
      randomize_stim();
      a = $urandom_range(0, 32'hFFFF);
      drive_fill(a);
      check_fill("random", a);
    end
  endtask

  initial begin
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    stim_exp = 1'b0; stim_noise = 1'b0; stim_gnt_dly = 0;
    test_reset();
    test_basic();
    test_delayed_gnt();
    test_exp();
    test_miss_during_beat();
    test_reset_mid_fill();
    test_rvalid_outside();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
